// File: rtl/projectile_ctl_pkg.sv
// Shared game types and constants for the projectile path.
package projectile_ctl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FLY  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int POS_W    = 13;
  localparam int SCREEN_W = 1024;
  localparam int GROUND_Y = 700;

endpackage

// File: rtl/projectile_step.sv
// One frame of projectile motion plus termination checks; purely combinational.
module projectile_step #(
  parameter int GROUND_Y   = 700,
  parameter int SCREEN_W   = 1024,
  parameter int GRAVITY    = 1,
  parameter int VY_MAX     = 31,
  parameter int TARGET_W   = 32,
  parameter int TARGET_H   = 32,
  parameter int MAX_FRAMES = 255,
  parameter int FC_W       = 8
) (
  input  logic signed [projectile_ctl_pkg::POS_W-1:0] pos_x,
  input  logic signed [projectile_ctl_pkg::POS_W-1:0] pos_y,
  input  logic signed [projectile_ctl_pkg::POS_W-1:0] vel_x,
  input  logic signed [projectile_ctl_pkg::POS_W-1:0] vel_y,
  input  logic        [11:0]                          target_x,
  input  logic        [11:0]                          target_y,
  input  logic        [FC_W-1:0]                      frame_cnt,
  output logic signed [projectile_ctl_pkg::POS_W-1:0] nxt_x,
  output logic signed [projectile_ctl_pkg::POS_W-1:0] nxt_y,
  output logic signed [projectile_ctl_pkg::POS_W-1:0] nxt_vy,
  output logic                                        term,
  output logic                                        hit
);
  import projectile_ctl_pkg::*;

  // One extra bit so target box edges (up to 4095+TARGET_W) compare without overflow.
  localparam int CW = POS_W + 1;

  logic signed [CW-1:0] nx_w, ny_w, tx_lo, ty_lo, vy_inc;
  logic                 ground, off_scr, timeout;

  always_comb begin
    nxt_x   = pos_x + vel_x;
    nxt_y   = pos_y + vel_y;
    vy_inc  = CW'(vel_y) + CW'(GRAVITY);
    nxt_vy  = (vy_inc > CW'(VY_MAX)) ? POS_W'(VY_MAX) : vy_inc[POS_W-1:0];

    nx_w    = CW'(nxt_x);
    ny_w    = CW'(nxt_y);
    tx_lo   = $signed({2'b00, target_x});
    ty_lo   = $signed({2'b00, target_y});

    hit     = (nx_w >= tx_lo) && (nx_w < tx_lo + CW'(TARGET_W)) &&
              (ny_w >= ty_lo) && (ny_w < ty_lo + CW'(TARGET_H));
    ground  = ny_w >= CW'(GROUND_Y);
    off_scr = nx_w[CW-1] || (nx_w > CW'(SCREEN_W - 1));
    timeout = frame_cnt == FC_W'(MAX_FRAMES - 1);
    term    = hit || ground || off_scr || timeout;
  end

endmodule

// File: rtl/projectile_ctl.sv
// Launches a projectile on a throw_enable rising edge, steps it once per frame_tick,
// and emits a single throw_done/hit pulse when the flight ends.
module projectile_ctl #(
  parameter int START_X    = 100,
  parameter int START_Y    = 600,
  parameter int GROUND_Y   = projectile_ctl_pkg::GROUND_Y,
  parameter int SCREEN_W   = projectile_ctl_pkg::SCREEN_W,
  parameter int GRAVITY    = 1,
  parameter int VY_MAX     = 31,
  parameter int TARGET_W   = 32,
  parameter int TARGET_H   = 32,
  parameter int MAX_FRAMES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        throw_enable,
  input  logic        frame_tick,
  input  logic [7:0]  vx_init,
  input  logic [7:0]  vy_init,
  input  logic [11:0] target_x,
  input  logic [11:0] target_y,
  output logic [11:0] proj_x,
  output logic [11:0] proj_y,
  output logic        proj_visible,
  output logic        throw_done,
  output logic        hit
);
  import projectile_ctl_pkg::*;

  localparam int FC_W = $clog2(MAX_FRAMES + 1);
  localparam logic signed [POS_W-1:0] SX = POS_W'(START_X);
  localparam logic signed [POS_W-1:0] SY = POS_W'(START_Y);

  state_t                   state_q, state_d;
  logic                     te_q, te_d, hit_q, hit_d, launch;
  logic signed [POS_W-1:0]  x_q, x_d, y_q, y_d, vx_q, vx_d, vy_q, vy_d;
  logic        [FC_W-1:0]   fc_q, fc_d;
  logic signed [POS_W-1:0]  nxt_x, nxt_y, nxt_vy;
  logic                     step_term, step_hit;

  projectile_step #(
    .GROUND_Y  (GROUND_Y),
    .SCREEN_W  (SCREEN_W),
    .GRAVITY   (GRAVITY),
    .VY_MAX    (VY_MAX),
    .TARGET_W  (TARGET_W),
    .TARGET_H  (TARGET_H),
    .MAX_FRAMES(MAX_FRAMES),
    .FC_W      (FC_W)
  ) u_step (
    .pos_x    (x_q),
    .pos_y    (y_q),
    .vel_x    (vx_q),
    .vel_y    (vy_q),
    .target_x (target_x),
    .target_y (target_y),
    .frame_cnt(fc_q),
    .nxt_x    (nxt_x),
    .nxt_y    (nxt_y),
    .nxt_vy   (nxt_vy),
    .term     (step_term),
    .hit      (step_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      te_q    <= 1'b0;
      hit_q   <= 1'b0;
      x_q     <= SX;
      y_q     <= SY;
      vx_q    <= '0;
      vy_q    <= '0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      te_q    <= te_d;
      hit_q   <= hit_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      fc_q    <= fc_d;
    end
  end

  always_comb begin
    launch  = throw_enable & ~te_q;
    te_d    = throw_enable;
    state_d = state_q;
    hit_d   = hit_q;
    x_d     = x_q;
    y_d     = y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    fc_d    = fc_q;
    case (state_q)
      S_IDLE: begin
        // A frame_tick in the launch cycle is deliberately dropped.
        if (launch) begin
          vx_d    = POS_W'($signed(vx_init));
          vy_d    = POS_W'($signed(vy_init));
          x_d     = SX;
          y_d     = SY;
          fc_d    = '0;
          hit_d   = 1'b0;
          state_d = S_FLY;
        end
      end
      S_FLY: begin
        if (frame_tick) begin
          x_d  = nxt_x;
          y_d  = nxt_y;
          vy_d = nxt_vy;
          fc_d = fc_q + FC_W'(1);
          if (step_term) begin
            hit_d   = step_hit;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        x_d     = SX;
        y_d     = SY;
        hit_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    proj_visible = state_q == S_FLY;
    throw_done   = state_q == S_DONE;
    hit          = hit_q;
    if (x_q[POS_W-1])                       proj_x = '0;
    else if (x_q > POS_W'(SCREEN_W - 1))    proj_x = 12'(SCREEN_W - 1);
    else                                    proj_x = x_q[11:0];
    proj_y = y_q[POS_W-1] ? 12'd0 : y_q[11:0];
  end

endmodule

// File: tb/tb_projectile_ctl.sv
// Self-checking bench for projectile_ctl: vector table, corner sequences, randomized flights.
module tb_projectile_ctl;

  logic        clk = 1'b0;
  logic        rst, throw_enable, frame_tick;
  logic [7:0]  vx_init, vy_init;
  logic [11:0] target_x, target_y;
  logic [11:0] px, py, gx, gy, tox, toy;
  logic        pv, pd, ph, gv, gd, gh, tv, td, th;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int vis_rise = 0;
  logic pv_prev = 1'b0;

  always #5 clk = ~clk;

  projectile_ctl u_dut (
    .clk(clk), .rst(rst), .throw_enable(throw_enable), .frame_tick(frame_tick),
    .vx_init(vx_init), .vy_init(vy_init), .target_x(target_x), .target_y(target_y),
    .proj_x(px), .proj_y(py), .proj_visible(pv), .throw_done(pd), .hit(ph)
  );

  projectile_ctl #(.START_Y(695)) u_gnd (
    .clk(clk), .rst(rst), .throw_enable(throw_enable), .frame_tick(frame_tick),
    .vx_init(vx_init), .vy_init(vy_init), .target_x(target_x), .target_y(target_y),
    .proj_x(gx), .proj_y(gy), .proj_visible(gv), .throw_done(gd), .hit(gh)
  );

  projectile_ctl #(.MAX_FRAMES(3)) u_to (
    .clk(clk), .rst(rst), .throw_enable(throw_enable), .frame_tick(frame_tick),
    .vx_init(vx_init), .vy_init(vy_init), .target_x(target_x), .target_y(target_y),
    .proj_x(tox), .proj_y(toy), .proj_visible(tv), .throw_done(td), .hit(th)
  );

  always @(negedge clk) begin
    if (pd === 1'b1) done_cnt++;
    if (pv === 1'b1 && pv_prev !== 1'b1) vis_rise++;
    pv_prev = pv;
  end

  typedef struct {
    string nm;
    int    vx, vy, tx, ty, n;
    int    ex, ey, edone, ehit;
  } vec_t;

  vec_t vec[9];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    throw_enable = 1'b0;
    frame_tick = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic launch(input int vx, input int vy, input int tx, input int ty);
    vx_init = 8'(vx);
    vy_init = 8'(vy);
    target_x = 12'(tx);
    target_y = 12'(ty);
    throw_enable = 1'b1;
    cyc();
    throw_enable = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  function automatic int clampx(input int v);
    return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
  endfunction

  initial begin
    int d0, r0;
    int gy_exp[4];
    int ty_exp[3];

    vec[0] = '{"basic_t1",     4, -10, 900, 100, 1,  104, 590, 0, 0};
    vec[1] = '{"basic_t2",     4, -10, 900, 100, 2,  108, 581, 0, 0};
    vec[2] = '{"target_hit",   4, -10, 108, 581, 2,  108, 581, 1, 1};
    vec[3] = '{"box_edge_in",  4, -10,  73, 559, 1,  104, 590, 1, 1};
    vec[4] = '{"box_edge_out", 4, -10,  72, 558, 1,  104, 590, 0, 0};
    vec[5] = '{"off_left",  -127,   0, 900, 100, 1,    0, 600, 1, 0};
    vec[6] = '{"off_right",  127,   0,   0,   0, 8, 1023, 628, 1, 0};
    vec[7] = '{"ground",       0, 127, 900, 100, 1,  100, 727, 1, 0};
    vec[8] = '{"hit_vs_grnd",  0, 127, 100, 720, 1,  100, 727, 1, 1};

    rst = 1'b1;
    throw_enable = 1'b0;
    frame_tick = 1'b0;
    vx_init = '0;
    vy_init = '0;
    target_x = '0;
    target_y = '0;
    cyc();
    chk("rst_x", px, 100);
    chk("rst_y", py, 600);
    chk("rst_vis", pv, 0);
    chk("rst_done", pd, 0);
    chk("rst_hit", ph, 0);
    rst = 1'b0;
    cyc();

    foreach (vec[i]) begin
      do_reset();
      launch(vec[i].vx, vec[i].vy, vec[i].tx, vec[i].ty);
      chk({vec[i].nm, "_vis_launch"}, pv, 1);
      for (int t = 1; t <= vec[i].n; t++) begin
        if (t > 1) begin
          cyc();
          cyc();
        end
        tick();
      end
      chk({vec[i].nm, "_x"}, px, vec[i].ex);
      chk({vec[i].nm, "_y"}, py, vec[i].ey);
      chk({vec[i].nm, "_done"}, pd, vec[i].edone);
      chk({vec[i].nm, "_hit"}, ph, vec[i].ehit);
      chk({vec[i].nm, "_vis"}, pv, 1 - vec[i].edone);
      cyc();
      if (vec[i].edone != 0) begin
        chk({vec[i].nm, "_done_clr"}, pd, 0);
        chk({vec[i].nm, "_vis_idle"}, pv, 0);
        chk({vec[i].nm, "_x_idle"}, px, 100);
      end else begin
        chk({vec[i].nm, "_x_hold"}, px, vec[i].ex);
        chk({vec[i].nm, "_vis_hold"}, pv, 1);
      end
    end

    // Ground miss from START_Y=695 with zero launch velocity.
    gy_exp = '{695, 696, 698, 701};
    do_reset();
    launch(0, 0, 900, 100);
    for (int t = 0; t < 4; t++) begin
      if (t > 0) begin
        cyc();
        cyc();
      end
      tick();
      chk("gnd_y", gy, gy_exp[t]);
      chk("gnd_x", gx, 100);
      chk("gnd_done", gd, (t == 3) ? 1 : 0);
      chk("gnd_vis", gv, (t == 3) ? 0 : 1);
    end
    chk("gnd_hit", gh, 0);
    cyc();
    chk("gnd_done_clr", gd, 0);
    chk("gnd_vis_idle", gv, 0);
    chk("gnd_y_idle", gy, 695);

    // Timeout with MAX_FRAMES=3 on an upward trajectory.
    ty_exp = '{590, 581, 573};
    do_reset();
    launch(0, -10, 900, 100);
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("to_y", toy, ty_exp[t]);
      chk("to_x", tox, 100);
      chk("to_done", td, (t == 2) ? 1 : 0);
      chk("to_vis", tv, (t == 2) ? 0 : 1);
      chk("to_hit", th, 0);
    end

    // Asynchronous reset mid-flight, asserted between clock edges.
    do_reset();
    launch(4, -10, 900, 100);
    tick();
    chk("arst_pre_vis", pv, 1);
    d0 = done_cnt;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_vis", pv, 0);
    chk("arst_x", px, 100);
    chk("arst_y", py, 600);
    cyc();
    cyc();
    rst = 1'b0;
    tick();
    cyc();
    chk("arst_no_done", done_cnt - d0, 0);
    chk("arst_idle_vis", pv, 0);

    // Launch coinciding with frame_tick, long hold, and a mid-flight re-edge.
    do_reset();
    vx_init = 8'(4);
    vy_init = 8'(-10);
    target_x = 12'd900;
    target_y = 12'd100;
    d0 = done_cnt;
    r0 = vis_rise;
    throw_enable = 1'b1;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    chk("hold_launch_vis", pv, 1);
    chk("hold_launch_x", px, 100);
    chk("hold_launch_y", py, 600);
    for (int c = 0; c < 2000; c++) begin
      frame_tick = (c % 20 == 10);
      throw_enable = (c != 300);
      cyc();
      frame_tick = 1'b0;
      if (c == 10) begin
        chk("hold_first_x", px, 104);
        chk("hold_first_y", py, 590);
      end
    end
    throw_enable = 1'b0;
    cyc();
    chk("hold_done_count", done_cnt - d0, 1);
    chk("hold_flight_count", vis_rise - r0, 1);

    // Randomized flights against a trajectory model.
    do_reset();
    for (int f = 0; f < 30; f++) begin
      int vx, vy, tx, ty, x, y, k, nx, ny;
      bit term, hv;
      vx = int'($urandom_range(40)) - 20;
      vy = int'($urandom_range(40)) - 30;
      tx = int'($urandom_range(400));
      ty = int'($urandom_range(700, 300));
      launch(vx, vy, tx, ty);
      chk("rnd_vis_launch", pv, 1);
      x = 100;
      y = 600;
      k = 0;
      term = 1'b0;
      while (!term && k < 300) begin
        repeat ($urandom_range(3)) cyc();
        tick();
        k++;
        nx = 100 + k * vx;
        ny = y + vy;
        vy = (vy + 1 > 31) ? 31 : vy + 1;
        hv = (nx >= tx) && (nx < tx + 32) && (ny >= ty) && (ny < ty + 32);
        term = hv || (ny >= 700) || (nx < 0) || (nx > 1023) || (k >= 255);
        x = nx;
        y = ny;
        chk("rnd_x", px, clampx(x));
        chk("rnd_y", py, (y < 0) ? 0 : y);
        chk("rnd_done", pd, term ? 1 : 0);
        chk("rnd_hit", ph, (term && hv) ? 1 : 0);
      end
      if (!term) chk("rnd_bound", 0, 1);
      cyc();
      chk("rnd_idle_vis", pv, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
